// File: rtl/bresenham_ctrl.sv
// ----------------------------------------------------------------------------
// bresenham_ctrl
// Sequences one range-sensor beam into occupancy-map writes. It accepts a
// beam, holds the beam parameters stable for the line datapath, and drives
// the datapath x-register. The endpoint cell gets one occupied write. The
// controller then walks one column at a time back toward the sensor and
// writes each cell as free. A walk longer than MAX_STEPS free writes is
// truncated and flagged.
//
// Ports
//   clock_i, reset_i            single clock, synchronous active-high reset
//   beam_valid_i / beam_ready_o beam handshake
//   beam_*_i                    beam range, bearing and sensor world pose
//   magnitude_o .. sensor_y_o   registered copy of the accepted beam
//   x_we_o, x_source_o          datapath x-register load (0) / step (1)
//   current_x_i                 signed column offset of the current cell
//   x_index_i, y_index_i        map cell of the current datapath position
//   ram_we_o .. ram_data_o      map write port (1 = occupied, 0 = free)
//   busy_o, done_o, truncated_o beam status
// ----------------------------------------------------------------------------
module bresenham_ctrl #(
    parameter int MAX_STEPS = 255,
    parameter int FIXED_W   = 16,
    parameter int X_IDX_W   = 8,
    parameter int Y_IDX_W   = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               beam_valid_i,
    output logic               beam_ready_o,
    input  logic [FIXED_W-1:0] beam_magnitude_i,
    input  logic [FIXED_W-1:0] beam_angle_i,
    input  logic [FIXED_W-1:0] beam_sensor_x_i,
    input  logic [FIXED_W-1:0] beam_sensor_y_i,
    output logic [FIXED_W-1:0] magnitude_o,
    output logic [FIXED_W-1:0] angle_o,
    output logic [FIXED_W-1:0] sensor_x_o,
    output logic [FIXED_W-1:0] sensor_y_o,
    output logic               x_we_o,
    output logic               x_source_o,
    input  logic [FIXED_W-1:0] current_x_i,
    input  logic [X_IDX_W-1:0] x_index_i,
    input  logic [Y_IDX_W-1:0] y_index_i,
    output logic               ram_we_o,
    output logic [X_IDX_W-1:0] ram_x_o,
    output logic [Y_IDX_W-1:0] ram_y_o,
    output logic               ram_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               truncated_o
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HIT  = 3'd2,
        ST_STEP = 3'd3,
        ST_FREE = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t             state_q;
    logic               beam_ready_q;
    logic [FIXED_W-1:0] magnitude_q;
    logic [FIXED_W-1:0] angle_q;
    logic [FIXED_W-1:0] sensor_x_q;
    logic [FIXED_W-1:0] sensor_y_q;
    logic               x_we_q;
    logic               x_source_q;
    logic               ram_we_q;
    logic [X_IDX_W-1:0] ram_x_q;
    logic [Y_IDX_W-1:0] ram_y_q;
    logic               ram_data_q;
    logic               busy_q;
    logic               done_q;
    logic               truncated_q;
    logic [CNT_W-1:0]   step_cnt_q;

    logic               cur_le0_s;
    logic               at_max_s;

    // Datapath position and step-budget conditions used by the FSM.
    always_comb begin
        cur_le0_s = current_x_i[FIXED_W-1] || (current_x_i == {FIXED_W{1'b0}});
        at_max_s  = (step_cnt_q == MAX_CNT);
    end

    // The datapath only presents the cell index in the same cycle as the
    // write strobe, so the address passes straight through while writing and
    // otherwise shows the last written cell; it never changes while idle.
    always_comb begin
        if (ram_we_q) begin
            ram_x_o = x_index_i;
            ram_y_o = y_index_i;
        end else begin
            ram_x_o = ram_x_q;
            ram_y_o = ram_y_q;
        end
    end

    // Beam sequencing FSM; every output is registered for the state being entered.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            beam_ready_q <= 1'b1;
            magnitude_q  <= {FIXED_W{1'b0}};
            angle_q      <= {FIXED_W{1'b0}};
            sensor_x_q   <= {FIXED_W{1'b0}};
            sensor_y_q   <= {FIXED_W{1'b0}};
            x_we_q       <= 1'b0;
            x_source_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_x_q      <= {X_IDX_W{1'b0}};
            ram_y_q      <= {Y_IDX_W{1'b0}};
            ram_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            truncated_q  <= 1'b0;
            step_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            x_we_q   <= 1'b0;
            ram_we_q <= 1'b0;
            done_q   <= 1'b0;
            if (ram_we_q) begin
                ram_x_q <= x_index_i;
                ram_y_q <= y_index_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (beam_valid_i) begin
                        magnitude_q  <= beam_magnitude_i;
                        angle_q      <= beam_angle_i;
                        sensor_x_q   <= beam_sensor_x_i;
                        sensor_y_q   <= beam_sensor_y_i;
                        step_cnt_q   <= {CNT_W{1'b0}};
                        truncated_q  <= 1'b0;
                        beam_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        x_we_q       <= 1'b1;
                        x_source_q   <= 1'b0;
                        state_q      <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    ram_we_q   <= 1'b1;
                    ram_data_q <= 1'b1;
                    state_q    <= ST_HIT;
                end
                ST_HIT: begin
                    if (cur_le0_s) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        x_we_q     <= 1'b1;
                        x_source_q <= 1'b1;
                        state_q    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // FREE leaves at MAX_CNT, so the counter cannot wrap.
                    step_cnt_q <= step_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    ram_we_q   <= 1'b1;
                    ram_data_q <= 1'b0;
                    state_q    <= ST_FREE;
                end
                ST_FREE: begin
                    if (cur_le0_s || at_max_s) begin
                        // Budget exhausted with cells still left toward the sensor.
                        truncated_q <= ~cur_le0_s;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        x_we_q     <= 1'b1;
                        x_source_q <= 1'b1;
                        state_q    <= ST_STEP;
                    end
                end
                ST_DONE: begin
                    beam_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    beam_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign beam_ready_o = beam_ready_q;
    assign magnitude_o  = magnitude_q;
    assign angle_o      = angle_q;
    assign sensor_x_o   = sensor_x_q;
    assign sensor_y_o   = sensor_y_q;
    assign x_we_o       = x_we_q;
    assign x_source_o   = x_source_q;
    assign ram_we_o     = ram_we_q;
    assign ram_data_o   = ram_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign truncated_o  = truncated_q;

endmodule

// File: tb/tb_bresenham_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bresenham_ctrl
// Directed bench for bresenham_ctrl (MAX_STEPS = 4) with a small line
// datapath model. The model's x-register loads magnitude_o as the endpoint
// column and steps down by one. Column index = sensor_x + current_x and
// row index = angle, both taken from the registered beam copy.
// ----------------------------------------------------------------------------
module tb_bresenham_ctrl;

    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          beam_valid_i;
    logic          beam_ready_o;
    logic [FW-1:0] beam_magnitude_i, beam_angle_i, beam_sensor_x_i, beam_sensor_y_i;
    logic [FW-1:0] magnitude_o, angle_o, sensor_x_o, sensor_y_o;
    logic          x_we_o, x_source_o;
    logic [FW-1:0] current_x_i;
    logic [7:0]    x_index_i, y_index_i;
    logic          ram_we_o;
    logic [7:0]    ram_x_o, ram_y_o;
    logic          ram_data_o, busy_o, done_o, truncated_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic signed [FW-1:0] dp_x;

    bresenham_ctrl #(.MAX_STEPS(4), .FIXED_W(FW), .X_IDX_W(8), .Y_IDX_W(8)) dut (
        .clock_i(clk), .reset_i(reset_i),
        .beam_valid_i(beam_valid_i), .beam_ready_o(beam_ready_o),
        .beam_magnitude_i(beam_magnitude_i), .beam_angle_i(beam_angle_i),
        .beam_sensor_x_i(beam_sensor_x_i), .beam_sensor_y_i(beam_sensor_y_i),
        .magnitude_o(magnitude_o), .angle_o(angle_o),
        .sensor_x_o(sensor_x_o), .sensor_y_o(sensor_y_o),
        .x_we_o(x_we_o), .x_source_o(x_source_o),
        .current_x_i(current_x_i), .x_index_i(x_index_i), .y_index_i(y_index_i),
        .ram_we_o(ram_we_o), .ram_x_o(ram_x_o), .ram_y_o(ram_y_o), .ram_data_o(ram_data_o),
        .busy_o(busy_o), .done_o(done_o), .truncated_o(truncated_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line datapath model: load endpoint or step one column toward the sensor.
    always @(posedge clk) begin
        if (reset_i)     dp_x <= '0;
        else if (x_we_o) dp_x <= x_source_o ? dp_x - 16'sd1 : $signed(magnitude_o);
    end

    assign current_x_i = dp_x;
    assign x_index_i   = sensor_x_o[7:0] + dp_x[7:0];
    assign y_index_i   = angle_o[7:0];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present a beam at a negedge with the DUT idle; return the cycle stamp of
    // the LOAD cycle that follows acceptance.
    task automatic start_beam(input logic [FW-1:0] mag, ang, sx, sy,
                              input logic hold, output int a);
        int n = 0;
        while (!beam_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_beam", beam_ready_o, 1);
        beam_valid_i     = 1'b1;
        beam_magnitude_i = mag;
        beam_angle_i     = ang;
        beam_sensor_x_i  = sx;
        beam_sensor_y_i  = sy;
        @(negedge clk);
        a = cyc;
        if (!hold) beam_valid_i = 1'b0;
        check_eq("accept_busy", busy_o, 1);
        check_eq("accept_mag", magnitude_o, mag);
        check_eq("accept_sy", sensor_y_o, sy);
    endtask

    // Follow the beam to done, checking every write, latency and truncation.
    task automatic finish_beam(input logic [FW-1:0] mag, ang, sx, input int nfree,
                               input logic trunc, input int a, input logic scramble);
        int   k = 0;
        int   dc = 0;
        logic got = 1'b0;
        logic [7:0] ex;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (scramble) begin
                beam_magnitude_i = 16'(100 + i);
                beam_angle_i     = 16'(200 + i);
                beam_sensor_x_i  = 16'(77 + i);
            end
            if (ram_we_o) begin
                ex = 8'(sx + mag - 16'(k));
                check_eq("wr_x", ram_x_o, ex);
                check_eq("wr_y", ram_y_o, ang[7:0]);
                check_eq("wr_data", ram_data_o, (k == 0) ? 1 : 0);
                k++;
            end
            if (done_o) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
        check_eq("done_seen", got, 1);
        check_eq("latency", dc - a + 1, 3 + 2 * nfree);
        check_eq("truncated", truncated_o, trunc);
        check_eq("write_count", k, 1 + nfree);
    endtask

    initial begin
        int   a;
        int   n;
        logic bad;
        reset_i          = 1'b1;
        beam_valid_i     = 1'b0;
        beam_magnitude_i = '0;
        beam_angle_i     = '0;
        beam_sensor_x_i  = '0;
        beam_sensor_y_i  = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_ready", beam_ready_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_trunc", truncated_o, 0);
        check_eq("rst_x_we", x_we_o, 0);
        check_eq("rst_x_src", x_source_o, 0);
        check_eq("rst_ram_we", ram_we_o, 0);
        check_eq("rst_ram_x", ram_x_o, 0);
        check_eq("rst_ram_y", ram_y_o, 0);
        check_eq("rst_ram_data", ram_data_o, 0);
        check_eq("rst_beam", {magnitude_o, angle_o, sensor_x_o, sensor_y_o}, 0);
        reset_i = 1'b0;
        @(negedge clk);

        // Endpoint 3: occupied at 13, free at 12, 11, 10; latency 9.
        start_beam(16'd3, 16'd7, 16'd10, 16'd1, 1'b0, a);
        finish_beam(16'd3, 16'd7, 16'd10, 3, 1'b0, a, 1'b0);

        // Endpoint 0: single occupied write, latency 3.
        start_beam(16'd0, 16'd4, 16'd30, 16'd2, 1'b0, a);
        finish_beam(16'd0, 16'd4, 16'd30, 0, 1'b0, a, 1'b0);

        // Negative endpoint -2 behaves like 0.
        start_beam(16'hFFFE, 16'd11, 16'd60, 16'd3, 1'b0, a);
        finish_beam(16'hFFFE, 16'd11, 16'd60, 0, 1'b0, a, 1'b0);

        // Endpoint 10 with a budget of 4: truncated after four free writes.
        start_beam(16'd10, 16'd2, 16'd5, 16'd4, 1'b0, a);
        finish_beam(16'd10, 16'd2, 16'd5, 4, 1'b1, a, 1'b0);

        // Endpoint 4 reaches the sensor exactly at the budget: not truncated.
        start_beam(16'd4, 16'd8, 16'd90, 16'd5, 1'b0, a);
        finish_beam(16'd4, 16'd8, 16'd90, 4, 1'b0, a, 1'b0);

        // beam_valid held with inputs changing mid-beam; next beam after done.
        start_beam(16'd2, 16'd5, 16'd40, 16'd6, 1'b1, a);
        finish_beam(16'd2, 16'd5, 16'd40, 2, 1'b0, a, 1'b1);
        beam_magnitude_i = 16'd1;
        beam_angle_i     = 16'd9;
        beam_sensor_x_i  = 16'd50;
        @(negedge clk);
        check_eq("hold_idle_ready", beam_ready_o, 1);
        check_eq("hold_idle_busy", busy_o, 0);
        @(negedge clk);
        a = cyc;
        check_eq("hold_second_busy", busy_o, 1);
        check_eq("hold_second_mag", magnitude_o, 16'd1);
        check_eq("hold_second_sx", sensor_x_o, 16'd50);
        beam_valid_i = 1'b0;
        finish_beam(16'd1, 16'd9, 16'd50, 1, 1'b0, a, 1'b0);

        // Reset in FREE of a 5-column beam aborts with no further activity.
        start_beam(16'd5, 16'd3, 16'd20, 16'd7, 1'b0, a);
        n = 0;
        while (!(ram_we_o && !ram_data_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_in_free", ram_we_o && !ram_data_o, 1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_eq("abort_busy", busy_o, 0);
        check_eq("abort_ram_we", ram_we_o, 0);
        check_eq("abort_ready", beam_ready_o, 1);
        check_eq("abort_done", done_o, 0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_o || ram_we_o || busy_o) bad = 1'b1;
        end
        check_eq("abort_quiet", bad, 0);

        // Recovery after abort.
        start_beam(16'd1, 16'd6, 16'd70, 16'd8, 1'b0, a);
        finish_beam(16'd1, 16'd6, 16'd70, 1, 1'b0, a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
